// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: execute-stage controls, instruction ROM port and decode handshake.
// The master modport is the fetch unit's view; slave is the surrounding pipeline/ROM.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              i_hold_flag;
  logic              i_jump_flag;
  logic [ADDR_W-1:0] i_jump_addr;
  logic              o_rom_req;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;
  logic [DATA_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_inst_addr;
  logic              o_inst_valid;
  logic              i_inst_ready;
  logic [ADDR_W-1:0] o_pc_addr;
  logic              o_misalign;

  modport master (
    input  i_hold_flag, i_jump_flag, i_jump_addr, i_rom_data, i_inst_ready,
    output o_rom_req, o_rom_addr, o_inst, o_inst_addr, o_inst_valid, o_pc_addr, o_misalign
  );

  modport slave (
    output i_hold_flag, i_jump_flag, i_jump_addr, i_rom_data, i_inst_ready,
    input  o_rom_req, o_rom_addr, o_inst, o_inst_addr, o_inst_valid, o_pc_addr, o_misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch into a synchronous ROM with an instruction FIFO toward decode.
// Optional misaligned-jump halt is enabled by defining PC_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic          i_Clk,
  input  logic          i_reset_n,
  fetch_unit_if.master  bus
);
  localparam int STEP  = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] jump_target;
  logic              infl_q, infl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] inst_mem_q [FIFO_DEPTH];

  logic jump, halted, credit_ok, issue, head_valid, push, pop;

  assign jump       = bus.i_jump_flag;
  // A request is only issued if the FIFO can absorb it alongside the one already in flight.
  assign credit_ok  = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, infl_q}) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue      = i_reset_n && !jump && !bus.i_hold_flag && !halted && credit_ok;
  assign head_valid = (cnt_q != '0);
  assign push       = infl_q && !jump;
  assign pop        = head_valid && !jump && bus.i_inst_ready;

`ifdef PC_MISALIGN_CHECK_EN
  logic halted_q;

  assign jump_target = bus.i_jump_addr;

  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      halted_q <= 1'b0;
    end else if (jump) begin
      halted_q <= |(bus.i_jump_addr & ADDR_W'(STEP - 1));
    end
  end

  assign halted         = halted_q;
  assign bus.o_misalign = halted_q;
`else
  assign jump_target    = bus.i_jump_addr & ~ADDR_W'(STEP - 1);
  assign halted         = 1'b0;
  assign bus.o_misalign = 1'b0;
`endif

  always_comb begin
    fpc_d    = fpc_q;
    infl_d   = 1'b0;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (jump) begin
      // Flush: the response to anything issued before the jump is never pushed.
      fpc_d    = jump_target;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (issue) begin
        fpc_d  = fpc_q + ADDR_W'(STEP);
        infl_d = 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fpc_q    <= RESET_VEC;
      infl_q   <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      infl_q   <= infl_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Datapath storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge i_Clk) begin
    if (issue) req_addr_q <= fpc_q;
    if (push) begin
      addr_mem_q[wr_ptr_q] <= req_addr_q;
      inst_mem_q[wr_ptr_q] <= bus.i_rom_data;
    end
  end

  assign bus.o_rom_req    = issue;
  assign bus.o_rom_addr   = fpc_q;
  assign bus.o_pc_addr    = fpc_q;
  assign bus.o_inst_valid = head_valid && !jump;
  assign bus.o_inst       = head_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.o_inst_addr  = head_valid ? addr_mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model plus an expected-instruction queue drained by a
// monitor on every decode handshake.
module tb_fetch_unit;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb_q[$];

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_VEC(32'h0), .FIFO_DEPTH(4)
  ) dut (
    .i_Clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {~a[15:0], a[15:0]};
  endfunction

  // Synchronous ROM: address sampled at the edge ending the request cycle.
  always @(posedge clk) begin
    if (bus.o_rom_req) bus.i_rom_data <= rom_word(bus.o_rom_addr);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.inst = rom_word(a);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input logic exp_req, input logic [31:0] exp_addr);
    chk("rom_req", {63'd0, bus.o_rom_req}, {63'd0, exp_req});
    if (exp_req) chk("rom_addr", {32'd0, bus.o_rom_addr}, {32'd0, exp_addr});
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_inst_valid && bus.i_inst_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected: got addr %0h with nothing expected", bus.o_inst_addr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_addr", {32'd0, bus.o_inst_addr}, {32'd0, e.addr});
        chk("sb_inst", {32'd0, bus.o_inst}, {32'd0, e.inst});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_hold_flag  = 1'b0;
    bus.i_jump_flag  = 1'b0;
    bus.i_jump_addr  = 32'h0;
    bus.i_inst_ready = 1'b1;
    bus.i_rom_data   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",       {63'd0, bus.o_rom_req},    64'd0);
    chk("rst_valid",     {63'd0, bus.o_inst_valid}, 64'd0);
    chk("rst_pc",        {32'd0, bus.o_pc_addr},    64'd0);
    chk("rst_inst",      {32'd0, bus.o_inst},       64'd0);
    chk("rst_inst_addr", {32'd0, bus.o_inst_addr},  64'd0);
    chk("rst_misalign",  {63'd0, bus.o_misalign},   64'd0);

    // Stream: cycle 0 starts here.
    rst_n = 1'b1;
    for (int a = 0; a <= 'h14; a += 4) push_exp(32'(a));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_req(1'b1, 32'(4 * k));
      if (k == 2) begin
        chk("first_valid", {63'd0, bus.o_inst_valid}, 64'd1);
        chk("first_inst",  {32'd0, bus.o_inst},       64'h13);
        chk("first_addr",  {32'd0, bus.o_inst_addr},  64'h0);
      end
      tick();
    end

    // Backpressure: restart at 0 with decode stalled.
    bus.i_jump_flag  = 1'b1;
    bus.i_jump_addr  = 32'h0;
    bus.i_inst_ready = 1'b0;
    @(negedge clk);
    chk("jump_valid_mask", {63'd0, bus.o_inst_valid}, 64'd0);
    chk_req(1'b0, 32'h0);
    tick();
    bus.i_jump_flag = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk_req(i <= 4, 32'(4 * (i - 1)));
      tick();
    end
    bus.i_inst_ready = 1'b1;
    for (int a = 0; a <= 'h14; a += 4) push_exp(32'(a));
    @(negedge clk);
    chk_req(1'b0, 32'h0);
    chk("full_valid", {63'd0, bus.o_inst_valid}, 64'd1);
    tick();
    @(negedge clk);
    chk_req(1'b1, 32'h10);
    tick();
    repeat (4) tick();

    // Jump with a response in flight.
    bus.i_jump_flag = 1'b1;
    bus.i_jump_addr = 32'h0;
    tick();
    bus.i_jump_flag = 1'b0;
    push_exp(32'h0);
    tick();
    tick();
    @(negedge clk);
    chk_req(1'b1, 32'h8);
    tick();
    bus.i_jump_flag = 1'b1;
    bus.i_jump_addr = 32'h100;
    push_exp(32'h100);
    push_exp(32'h104);
    push_exp(32'h108);
    @(negedge clk);
    chk("jmp_valid_mask", {63'd0, bus.o_inst_valid}, 64'd0);
    tick();
    bus.i_jump_flag = 1'b0;
    @(negedge clk);
    chk_req(1'b1, 32'h100);
    chk("jmp_flushed", {63'd0, bus.o_inst_valid}, 64'd0);
    tick();
    @(negedge clk);
    chk("jmp_empty_j2", {63'd0, bus.o_inst_valid}, 64'd0);
    tick();
    @(negedge clk);
    chk("jmp_valid_j3", {63'd0, bus.o_inst_valid}, 64'd1);
    chk("jmp_addr_j3",  {32'd0, bus.o_inst_addr},  64'h100);
    tick();

    // Hold for three cycles.
    bus.i_hold_flag = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_req(1'b0, 32'h0);
      chk("hold_pc", {32'd0, bus.o_pc_addr}, 64'h10C);
      tick();
    end
    bus.i_hold_flag = 1'b0;
    @(negedge clk);
    chk_req(1'b1, 32'h10C);
    tick();
    bus.i_inst_ready = 1'b0;
    tick();
    tick();

    // Asynchronous reset with two entries buffered.
    #2;
    chk("pre_rst_valid", {63'd0, bus.o_inst_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, bus.o_inst_valid}, 64'd0);
    chk("arst_pc",    {32'd0, bus.o_pc_addr},    64'h0);
    chk("arst_req",   {63'd0, bus.o_rom_req},    64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_inst_ready = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    @(negedge clk);
    chk_req(1'b1, 32'h0);
    repeat (4) tick();

    // Jump to a misaligned target.
    bus.i_jump_flag = 1'b1;
    bus.i_jump_addr = 32'h102;
    tick();
    bus.i_jump_flag = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    repeat (3) begin
      @(negedge clk);
      chk("mis_flag", {63'd0, bus.o_misalign}, 64'd1);
      chk_req(1'b0, 32'h0);
      chk("mis_valid", {63'd0, bus.o_inst_valid}, 64'd0);
      tick();
    end
    bus.i_jump_flag = 1'b1;
    bus.i_jump_addr = 32'h200;
    push_exp(32'h200);
    tick();
    bus.i_jump_flag = 1'b0;
    @(negedge clk);
    chk("mis_clear", {63'd0, bus.o_misalign}, 64'd0);
    chk_req(1'b1, 32'h200);
    repeat (3) tick();
    bus.i_inst_ready = 1'b0;
`else
    push_exp(32'h100);
    @(negedge clk);
    chk("mis_tied", {63'd0, bus.o_misalign}, 64'd0);
    chk_req(1'b1, 32'h100);
    repeat (3) tick();
    bus.i_inst_ready = 1'b0;
`endif
    repeat (3) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
